r88_int_seq: RTL and testbench
==============================

# r88_int_seq

Interrupt and reset sequencer for the Rocket88 core. It arbitrates reset, NMI, BRK and IRQ events and, at an instruction boundary, takes over the memory-sequencing path from the instruction decoder. It steps through the PC/flag push and vector fetch cycles, then hands control back. It sits beside the decoder and drives the same `readMem`/`writeMem` strobes through a mux selected by `seqActive`.

## Interface
- No parameters.
- `sysClock` in 1: system clock, rising-edge.
- `sysReset_n` in 1: asynchronous, active-low reset.
- `nmiReq` in 1: NMI request; rising edge is latched.
- `irq` in 1: level interrupt request.
- `irqEn` in 1: interrupt-enable flag from the decoder; masks `irq` only.
- `brkReq` in 1: one-cycle pulse from the decoder when it decodes BRK.
- `opBoundary` in 1: high in the cycle the decoder would start an opcode fetch.
- `memReady` in 1: high when the bus completes the current access this cycle.
- `seqActive` out 1: sequencer owns the bus and stalls the decoder.
- `seqStep` out 3: current step; see Operation.
- `readMem` out 1: read strobe for the current step.
- `writeMem` out 1: write strobe for the current step.
- `vecAddr` out 16: address of the vector byte for the current fetch step.
- `setBreak` out 1: asserted during PUSH_F of a BRK sequence.
- `clrIrqEn` out 1: one-cycle pulse on completion of any NMI/BRK/IRQ sequence.
- `seqDone` out 1: one-cycle pulse on the final step's completion.
- `nmiPending` out 1: NMI latch state.

## Operation
- Step encoding on `seqStep`:
  - 0 IDLE
  - 1 PUSH_PCH
  - 2 PUSH_PCL
  - 3 PUSH_F
  - 4 VEC_LO
  - 5 VEC_HI
- Write steps: PUSH_PCH, PUSH_PCL and PUSH_F assert `writeMem`.
- Read steps: VEC_LO and VEC_HI assert `readMem`.
- Pending events:
  - Reset: set by reset deassertion.
  - NMI: latched on the rising edge of `nmiReq`.
  - BRK: latched on `brkReq`.
  - IRQ: `irq & irqEn`, sampled live and not latched.
- Priority: reset > NMI > BRK > IRQ.
- Sequence start: in IDLE with `opBoundary`=1 and any event pending, the highest-priority event is selected and the sequence starts next cycle.
- Reset sequence: VEC_LO → VEC_HI only. No pushes, `vecAddr`=0xFFFC/0xFFFD, `clrIrqEn` not pulsed.
- NMI sequence: PUSH_PCH → PUSH_PCL → PUSH_F → VEC_LO → VEC_HI with vector 0xFFFA/0xFFFB. The NMI latch clears on entering PUSH_PCH.
- BRK sequence: same steps, vector 0xFFFE/0xFFFF, `setBreak`=1 during PUSH_F. The BRK latch clears on entering PUSH_PCH.
- IRQ sequence: same as BRK but `setBreak`=0.
- Vector selection is frozen at sequence start. Events arriving mid-sequence stay pending; there is no hijacking.
- `vecAddr` is 0x0000 outside the VEC steps.
- A new NMI edge during an active NMI sequence re-sets the latch, and that NMI is serviced at the next boundary.
- If IRQ drops or `irqEn` clears before the boundary, no IRQ sequence is taken.

## Timing
- Each step holds until `memReady`=1; it advances on that clock edge.
- Minimum durations (with `memReady` held high):
  - Full sequence: 5 cycles.
  - Reset sequence: 2 cycles.
- `seqActive` rises the cycle after the qualifying `opBoundary`. It falls the cycle after VEC_HI completes.
- `seqDone` and `clrIrqEn` are high in the cycle VEC_HI completes.
- Reset values, while `sysReset_n`=0:
  - Step and outputs: step=IDLE, `seqActive`=0, `readMem`=0, `writeMem`=0, `vecAddr`=0, `setBreak`=0, `seqDone`=0, `clrIrqEn`=0.
  - Latches: NMI and BRK latches cleared.
  - Edge detector: history register cleared.
  - Reset-pending: set.
- After reset release: the first clock enters VEC_LO directly, without waiting for `opBoundary`.
- Reset assertion mid-sequence aborts immediately and asynchronously. The reset sequence follows on release.
- NMI edge detection: `nmiReq` passes through a 2-flop synchronizer. Latch-to-pending latency is 3 cycles.

## Configuration
- `R88_NMI_EN` defined: NMI path as above.
- `R88_NMI_EN` undefined:
  - `nmiReq` is ignored and no synchronizer or latch is built.
  - `nmiPending` is tied to 0.
  - Vector 0xFFFA is never issued.
  - Priority becomes reset > BRK > IRQ.

## Structure
- Package `r88_pkg` holds:
  - The 3-bit step encoding constants.
  - The vector base constants 0xFFFA, 0xFFFC and 0xFFFE.
  - The 2-bit event-select encoding.
- Sub-module `r88_edge_sync`: 2-flop synchronizer plus rising-edge pulse. It is instantiated only under `R88_NMI_EN`.

## Test plan
- Reset then release with `memReady`=1 → steps 4,5 on cycles 1–2; `vecAddr` 0xFFFC, 0xFFFD; `seqDone` on cycle 2; no writes.
- `irq`=1, `irqEn`=1, `opBoundary` pulse → steps 1–5, `writeMem` on steps 1–3, `vecAddr` 0xFFFE/0xFFFF, `clrIrqEn` once; repeat with `irqEn`=0 → stays IDLE.
- `brkReq` and `irq` and NMI edge all pending at one boundary → NMI sequence first (0xFFFA), then BRK (`setBreak`=1 in PUSH_F), then IRQ.
- `memReady` low for 3 cycles during PUSH_PCL → step holds at 2 with `writeMem` asserted, then resumes; total 8 cycles.
- `sysReset_n` pulsed low during VEC_LO of an IRQ sequence → outputs zero immediately; the reset sequence runs on release.
- Build without `R88_NMI_EN`, toggle `nmiReq` at a boundary → no sequence, `nmiPending`=0.

Source files
------------

// File: rtl/r88_pkg.sv
// Shared encodings for the Rocket88 interrupt/reset sequencer: step codes,
// event-select codes and vector base addresses.
package r88_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PUSH_PCH = 3'd1,
    PUSH_PCL = 3'd2,
    PUSH_F   = 3'd3,
    VEC_LO   = 3'd4,
    VEC_HI   = 3'd5
  } stepState_e;

  typedef enum logic [1:0] {
    EV_RST = 2'd0,
    EV_NMI = 2'd1,
    EV_BRK = 2'd2,
    EV_IRQ = 2'd3
  } evSel_e;

  localparam logic [15:0] VEC_NMI = 16'hFFFA;
  localparam logic [15:0] VEC_RST = 16'hFFFC;
  localparam logic [15:0] VEC_BRK = 16'hFFFE;

  // BRK and IRQ share a vector; the low byte address is always even.
  function automatic logic [15:0] vecBase(input evSel_e ev);
    case (ev)
      EV_RST:  vecBase = VEC_RST;
      EV_NMI:  vecBase = VEC_NMI;
      default: vecBase = VEC_BRK;
    endcase
  endfunction

endpackage

// File: rtl/r88_edge_sync.sv
// Two-flop synchronizer with a rising-edge pulse on the synchronized signal.
// Only compiled when R88_NMI_EN is defined, since only the NMI path uses it.
`ifdef R88_NMI_EN
module r88_edge_sync (
  input  logic sysClock,
  input  logic sysReset_n,
  input  logic syncIn,
  output logic risePulse
);

  logic sync1Reg;
  logic sync2Reg;
  logic histReg;

  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      sync1Reg <= 1'b0;
      sync2Reg <= 1'b0;
      histReg  <= 1'b0;
    end else begin
      sync1Reg <= syncIn;
      sync2Reg <= sync1Reg;
      histReg  <= sync2Reg;
    end
  end

  assign risePulse = sync2Reg & ~histReg;

endmodule
`endif

// File: rtl/r88_int_seq.sv
// Rocket88 interrupt/reset sequencer: arbitrates reset, NMI, BRK and IRQ and
// drives the push/vector-fetch bus cycles. NMI support is built under R88_NMI_EN.
module r88_int_seq
  import r88_pkg::*;
(
  input  logic        sysClock,
  input  logic        sysReset_n,
  input  logic        nmiReq,
  input  logic        irq,
  input  logic        irqEn,
  input  logic        brkReq,
  input  logic        opBoundary,
  input  logic        memReady,
  output logic        seqActive,
  output logic [2:0]  seqStep,
  output logic        readMem,
  output logic        writeMem,
  output logic [15:0] vecAddr,
  output logic        setBreak,
  output logic        clrIrqEn,
  output logic        seqDone,
  output logic        nmiPending
);

  stepState_e stepReg, stepNext;
  evSel_e     evReg, evNext;
  logic       rstPendReg;
  logic       brkLatchReg;
  logic       nmiPend;
  logic       irqLive;
  logic       startSeq;

  assign irqLive = irq & irqEn;

`ifdef R88_NMI_EN
  logic nmiEdge;
  logic nmiLatchReg;

  r88_edge_sync uNmiSync (
    .sysClock   (sysClock),
    .sysReset_n (sysReset_n),
    .syncIn     (nmiReq),
    .risePulse  (nmiEdge)
  );

  // A fresh edge wins over the clear so an NMI during its own start is kept.
  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      nmiLatchReg <= 1'b0;
    end else if (nmiEdge) begin
      nmiLatchReg <= 1'b1;
    end else if (startSeq && evNext == EV_NMI) begin
      nmiLatchReg <= 1'b0;
    end
  end

  assign nmiPend = nmiLatchReg;
`else
  logic unusedNmiReq;
  assign unusedNmiReq = nmiReq;
  assign nmiPend      = 1'b0;
`endif

  assign nmiPending = nmiPend;

  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      stepReg <= IDLE;
      evReg   <= EV_RST;
    end else begin
      stepReg <= stepNext;
      evReg   <= evNext;
    end
  end

  always_ff @(posedge sysClock or negedge sysReset_n) begin
    if (!sysReset_n) begin
      rstPendReg  <= 1'b1;
      brkLatchReg <= 1'b0;
    end else begin
      // Reset-pending always leaves IDLE on the first clock after release.
      if (stepReg == IDLE) begin
        rstPendReg <= 1'b0;
      end
      if (brkReq) begin
        brkLatchReg <= 1'b1;
      end else if (startSeq && evNext == EV_BRK) begin
        brkLatchReg <= 1'b0;
      end
    end
  end

  always_comb begin
    stepNext = stepReg;
    evNext   = evReg;
    startSeq = 1'b0;
    case (stepReg)
      IDLE: begin
        if (rstPendReg) begin
          stepNext = VEC_LO;
          evNext   = EV_RST;
        end else if (opBoundary && (nmiPend || brkLatchReg || irqLive)) begin
          stepNext = PUSH_PCH;
          startSeq = 1'b1;
          if (nmiPend) begin
            evNext = EV_NMI;
          end else if (brkLatchReg) begin
            evNext = EV_BRK;
          end else begin
            evNext = EV_IRQ;
          end
        end
      end
      PUSH_PCH: if (memReady) stepNext = PUSH_PCL;
      PUSH_PCL: if (memReady) stepNext = PUSH_F;
      PUSH_F:   if (memReady) stepNext = VEC_LO;
      VEC_LO:   if (memReady) stepNext = VEC_HI;
      VEC_HI:   if (memReady) stepNext = IDLE;
      default:  stepNext = IDLE;
    endcase
  end

  always_comb begin
    seqActive = (stepReg != IDLE);
    seqStep   = stepReg;
    writeMem  = (stepReg == PUSH_PCH) || (stepReg == PUSH_PCL) || (stepReg == PUSH_F);
    readMem   = (stepReg == VEC_LO) || (stepReg == VEC_HI);
    vecAddr   = 16'h0000;
    if (stepReg == VEC_LO) begin
      vecAddr = vecBase(evReg);
    end else if (stepReg == VEC_HI) begin
      vecAddr = vecBase(evReg) | 16'h0001;
    end
    setBreak = (stepReg == PUSH_F) && (evReg == EV_BRK);
    seqDone  = (stepReg == VEC_HI) && memReady;
    clrIrqEn = seqDone && (evReg != EV_RST);
  end

endmodule

// File: tb/tb_r88_int_seq.sv
// Directed bench for r88_int_seq; NMI-specific checks follow R88_NMI_EN.
module tb_r88_int_seq;

  logic        sysClock = 1'b0;
  logic        sysReset_n;
  logic        nmiReq, irq, irqEn, brkReq, opBoundary, memReady;
  logic        seqActive;
  logic [2:0]  seqStep;
  logic        readMem, writeMem;
  logic [15:0] vecAddr;
  logic        setBreak, clrIrqEn, seqDone, nmiPending;

  int nAssert = 0;
  int nFail   = 0;
  int activeCycles = 0;

  always #5 sysClock = ~sysClock;

  always @(negedge sysClock) if (seqActive === 1'b1) activeCycles++;

  r88_int_seq dut (
    .sysClock   (sysClock),
    .sysReset_n (sysReset_n),
    .nmiReq     (nmiReq),
    .irq        (irq),
    .irqEn      (irqEn),
    .brkReq     (brkReq),
    .opBoundary (opBoundary),
    .memReady   (memReady),
    .seqActive  (seqActive),
    .seqStep    (seqStep),
    .readMem    (readMem),
    .writeMem   (writeMem),
    .vecAddr    (vecAddr),
    .setBreak   (setBreak),
    .clrIrqEn   (clrIrqEn),
    .seqDone    (seqDone),
    .nmiPending (nmiPending)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkOut(input string tag, input logic [2:0] step, input logic rd,
                        input logic wr, input logic [15:0] vec, input logic sb,
                        input logic clr, input logic done);
    chk({tag, "/step"},   {13'd0, seqStep},   {13'd0, step});
    chk({tag, "/active"}, {15'd0, seqActive}, {15'd0, step != 3'd0});
    chk({tag, "/rd"},     {15'd0, readMem},   {15'd0, rd});
    chk({tag, "/wr"},     {15'd0, writeMem},  {15'd0, wr});
    chk({tag, "/vec"},    vecAddr,            vec);
    chk({tag, "/brk"},    {15'd0, setBreak},  {15'd0, sb});
    chk({tag, "/clr"},    {15'd0, clrIrqEn},  {15'd0, clr});
    chk({tag, "/done"},   {15'd0, seqDone},   {15'd0, done});
  endtask

  task automatic tick;
    @(posedge sysClock);
    #1;
  endtask

  // Start at a boundary, then walk the five steps with memReady held high.
  task automatic runSeq(input string tag, input logic [15:0] base, input logic brk);
    logic [15:0] v;
    opBoundary = 1'b1;
    #1;
    chkOut({tag, "/start"}, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    opBoundary = 1'b0;
    #1;
    for (int i = 1; i <= 5; i++) begin
      v = (i == 4) ? base : (i == 5) ? (base + 16'd1) : 16'h0000;
      chkOut($sformatf("%s/s%0d", tag, i), 3'(i), i >= 4, i <= 3, v,
             brk && (i == 3), i == 5, i == 5);
      tick;
    end
    chkOut({tag, "/end"}, 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    $display("sequence %s vector %h checked", tag, base);
  endtask

  initial begin
    sysReset_n = 1'b0;
    nmiReq = 1'b0; irq = 1'b0; irqEn = 1'b0; brkReq = 1'b0;
    opBoundary = 1'b0; memReady = 1'b1;
    #3;
    chkOut("rst/hold", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("rst/nmiPending", {15'd0, nmiPending}, 16'd0);
    tick;
    tick;
    chkOut("rst/hold2", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);

    // Reset release: VEC_LO/VEC_HI immediately, no boundary needed.
    sysReset_n = 1'b1;
    tick;
    chkOut("rstseq/c1", 3'd4, 1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("rstseq/c2", 3'd5, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b1);
    tick;
    chkOut("rstseq/c3", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    $display("sequence reset vector fffc checked");

    // IRQ with enable
    irq = 1'b1; irqEn = 1'b1;
    runSeq("irq", 16'hFFFE, 1'b0);

    // IRQ masked: boundary must not start anything
    irqEn = 1'b0; opBoundary = 1'b1;
    #1;
    tick;
    chkOut("irqmask/c1", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("irqmask/c2", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    opBoundary = 1'b0;
    $display("irq masked: stayed idle");

    // All events pending at one boundary
    irqEn = 1'b1; brkReq = 1'b1; nmiReq = 1'b1;
    tick;
    brkReq = 1'b0;
    tick;
    chk("prio/nmiPend2", {15'd0, nmiPending}, 16'd0);
    tick;
`ifdef R88_NMI_EN
    chk("prio/nmiPend3", {15'd0, nmiPending}, 16'd1);
    runSeq("nmi", 16'hFFFA, 1'b0);
    chk("prio/nmiCleared", {15'd0, nmiPending}, 16'd0);
`else
    chk("prio/nmiPend3", {15'd0, nmiPending}, 16'd0);
`endif
    runSeq("brk", 16'hFFFE, 1'b1);
    runSeq("irq2", 16'hFFFE, 1'b0);
    irq = 1'b0; nmiReq = 1'b0;
    tick;
    tick;
    tick;

    // Three wait states in PUSH_PCL stretch the sequence to eight cycles
    activeCycles = 0;
    irq = 1'b1; opBoundary = 1'b1;
    #1;
    tick;
    opBoundary = 1'b0; irq = 1'b0;
    #1;
    chkOut("stall/pch", 3'd1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    memReady = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chkOut($sformatf("stall/hold%0d", i), 3'd2, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
      tick;
    end
    memReady = 1'b1;
    #1;
    chkOut("stall/pcl", 3'd2, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("stall/f", 3'd3, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("stall/vlo", 3'd4, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("stall/vhi", 3'd5, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    tick;
    chkOut("stall/end", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("stall/cycles", 16'(activeCycles), 16'd8);
    $display("stall sequence active for %0d cycles", activeCycles);

    // Reset during VEC_LO of an IRQ sequence
    irq = 1'b1; opBoundary = 1'b1;
    #1;
    tick;
    opBoundary = 1'b0; irq = 1'b0;
    tick;
    tick;
    tick;
    chkOut("abort/vlo", 3'd4, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    sysReset_n = 1'b0;
    #1;
    chkOut("abort/now", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("abort/held", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    sysReset_n = 1'b1;
    tick;
    chkOut("abort/rlo", 3'd4, 1'b1, 1'b0, 16'hFFFC, 1'b0, 1'b0, 1'b0);
    tick;
    chkOut("abort/rhi", 3'd5, 1'b1, 1'b0, 16'hFFFD, 1'b0, 1'b0, 1'b1);
    tick;
    chkOut("abort/end", 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    $display("reset abort and reset sequence checked");

`ifndef R88_NMI_EN
    // Without NMI support, nmiReq toggles must be ignored
    opBoundary = 1'b1;
    for (int i = 0; i < 6; i++) begin
      nmiReq = ~nmiReq;
      tick;
      chkOut($sformatf("nonmi/c%0d", i), 3'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
      chk($sformatf("nonmi/pend%0d", i), {15'd0, nmiPending}, 16'd0);
    end
    opBoundary = 1'b0;
    $display("nmiReq ignored without NMI support");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
